// File: rtl/pll_lock_sequencer_if.sv
// PLL-side and status signals of the lock sequencer.
// master: the sequencer; slave: the PLL/board side that supplies pll_locked.
interface pll_lock_sequencer_if;
  logic       pll_locked;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic       fault;
  logic [1:0] retry_count;
  logic [7:0] loss_count;

  modport master (
    input  pll_locked,
    output pll_rst, sys_rst, ready, fault, retry_count, loss_count
  );

  modport slave (
    output pll_locked,
    input  pll_rst, sys_rst, ready, fault, retry_count, loss_count
  );
endinterface

// File: rtl/pll_lock_sequencer.sv
// PLL bring-up sequencer: pulses the PLL reset, waits for lock with a timeout and
// bounded retries, qualifies lock stability, then releases the downstream reset.
// Lock loss while running counts a loss event and restarts the whole bring-up.
module pll_lock_sequencer #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 3,
  parameter int CNT_W         = 16
) (
  input  logic                 refclk,
  input  logic                 rst,
  pll_lock_sequencer_if.master pll
);

  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STB_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [1:0]       RETRY_MAX = 2'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_RESET_PLL = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN       = 3'd3,
    S_FAULT     = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [1:0]       retry_cnt, retry_nxt;
  logic [7:0]       loss_cnt, loss_nxt;
  logic [1:0]       lock_pipe;
  logic             locked_s;

  assign locked_s = lock_pipe[1];

  // Two-flop synchroniser for the asynchronous PLL lock flag.
  always_ff @(posedge refclk) begin
    if (rst) lock_pipe <= '0;
    else     lock_pipe <= {lock_pipe[0], pll.pll_locked};
  end

  // State, shared counter and status counters.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state     <= S_RESET_PLL;
      cnt       <= '0;
      retry_cnt <= '0;
      loss_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      retry_cnt <= retry_nxt;
      loss_cnt  <= loss_nxt;
    end
  end

  // Next-state and counter updates; every transition clears the counter so it never wraps.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    retry_nxt = retry_cnt;
    loss_nxt  = loss_cnt;
    case (state)
      S_RESET_PLL: begin
        if (cnt == RST_LAST) begin
          state_nxt = S_WAIT_LOCK;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      S_WAIT_LOCK: begin
        // Lock takes priority over a coincident timeout.
        if (locked_s) begin
          state_nxt = S_STABLE;
          cnt_nxt   = '0;
        end else if (cnt == TO_LAST) begin
          cnt_nxt = '0;
          if (retry_cnt < RETRY_MAX) begin
            retry_nxt = retry_cnt + 2'd1;
            state_nxt = S_RESET_PLL;
          end else begin
            state_nxt = S_FAULT;
          end
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      S_STABLE: begin
        // A lock drop restarts the timeout window without consuming a retry.
        if (!locked_s) begin
          state_nxt = S_WAIT_LOCK;
          cnt_nxt   = '0;
        end else if (cnt == STB_LAST) begin
          state_nxt = S_RUN;
          cnt_nxt   = '0;
          retry_nxt = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      S_RUN: begin
        cnt_nxt = '0;
        if (!locked_s) begin
          state_nxt = S_RESET_PLL;
          retry_nxt = '0;
          if (loss_cnt != 8'hff) loss_nxt = loss_cnt + 8'd1;
        end
      end
      S_FAULT: begin
        cnt_nxt = '0;
      end
      default: begin
        state_nxt = S_RESET_PLL;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Moore output decode straight from the state register.
  always_comb begin
    pll.pll_rst = 1'b1;
    pll.sys_rst = 1'b1;
    pll.ready   = 1'b0;
    pll.fault   = 1'b0;
    case (state)
      S_WAIT_LOCK, S_STABLE: pll.pll_rst = 1'b0;
      S_RUN: begin
        pll.pll_rst = 1'b0;
        pll.sys_rst = 1'b0;
        pll.ready   = 1'b1;
      end
      S_FAULT: pll.fault = 1'b1;
      default: ;
    endcase
  end

  assign pll.retry_count = retry_cnt;
  assign pll.loss_count  = loss_cnt;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Bench for pll_lock_sequencer: directed scenarios with literal expectations, then
// randomized lock/reset traffic, all checked every cycle against a phase/elapsed-time model.
module tb_pll_lock_sequencer;
  localparam int RST_CYCLES    = 4;
  localparam int LOCK_TIMEOUT  = 20;
  localparam int STABLE_CYCLES = 8;
  localparam int MAX_RETRIES   = 2;

  logic refclk = 1'b0;
  logic rst    = 1'b1;
  pll_lock_sequencer_if bus();

  pll_lock_sequencer #(
    .RST_CYCLES(RST_CYCLES), .LOCK_TIMEOUT(LOCK_TIMEOUT), .STABLE_CYCLES(STABLE_CYCLES),
    .MAX_RETRIES(MAX_RETRIES), .CNT_W(16)
  ) dut (
    .refclk(refclk),
    .rst   (rst),
    .pll   (bus)
  );

  always #10 refclk = ~refclk;

  int    n_chk = 0;
  int    n_err = 0;
  bit    chk_en = 1'b0;

  // Reference model: named phase, edges spent in that phase, retry and loss tallies.
  string m_phase = "PLLRST";
  int    m_t = 0;
  int    m_retries = 0;
  int    m_losses = 0;
  bit    m_hist[2] = '{1'b0, 1'b0};   // pll_locked as seen one and two edges ago

  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit ls;
    ls = m_hist[1];
    if (rst) begin
      m_phase = "PLLRST"; m_t = 0; m_retries = 0; m_losses = 0;
      m_hist[0] = 1'b0; m_hist[1] = 1'b0;
      return;
    end
    m_hist[1] = m_hist[0];
    m_hist[0] = bus.pll_locked;
    if (m_phase == "PLLRST") begin
      m_t++;
      if (m_t == RST_CYCLES) begin m_phase = "WAIT"; m_t = 0; end
    end else if (m_phase == "WAIT") begin
      if (ls) begin
        m_phase = "QUAL"; m_t = 0;
      end else begin
        m_t++;
        if (m_t == LOCK_TIMEOUT) begin
          m_t = 0;
          if (m_retries < MAX_RETRIES) begin m_retries++; m_phase = "PLLRST"; end
          else m_phase = "FAULT";
        end
      end
    end else if (m_phase == "QUAL") begin
      if (!ls) begin
        m_phase = "WAIT"; m_t = 0;
      end else begin
        m_t++;
        if (m_t == STABLE_CYCLES) begin m_phase = "RUN"; m_t = 0; m_retries = 0; end
      end
    end else if (m_phase == "RUN") begin
      if (!ls) begin
        m_losses = (m_losses < 255) ? m_losses + 1 : 255;
        m_phase = "PLLRST"; m_t = 0; m_retries = 0;
      end
    end
  endtask

  task automatic compare();
    bit run, flt;
    run = (m_phase == "RUN");
    flt = (m_phase == "FAULT");
    chk("pll_rst", int'(bus.pll_rst), int'(m_phase == "PLLRST" || flt));
    chk("sys_rst", int'(bus.sys_rst), int'(!run));
    chk("ready", int'(bus.ready), int'(run));
    chk("fault", int'(bus.fault), int'(flt));
    chk("retry_count", int'(bus.retry_count), m_retries);
    chk("loss_count", int'(bus.loss_count), m_losses);
  endtask

  // One clock: DUT edge, then model step and full compare at the falling edge.
  task automatic cyc(int n);
    for (int i = 0; i < n; i++) begin
      @(posedge refclk);
      @(negedge refclk);
      model_step();
      if (chk_en) compare();
    end
  endtask

  task automatic do_reset(int n);
    rst = 1'b1;
    cyc(n);
    rst = 1'b0;
  endtask

  task automatic wait_ready(int lim);
    int k;
    k = 0;
    while (!bus.ready && k < lim) begin cyc(1); k++; end
    chk("wait_ready_timeout", int'(bus.ready), 1);
  endtask

  task automatic wait_qual(int at_t, int lim);
    int k;
    k = 0;
    while (!(m_phase == "QUAL" && m_t == at_t) && k < lim) begin cyc(1); k++; end
    chk("wait_stable_timeout", int'(m_phase == "QUAL" && m_t == at_t), 1);
  endtask

  initial begin
    bus.pll_locked = 1'b0;
    rst = 1'b1;
    cyc(1);
    chk_en = 1'b1;

    // 1: reset 3 cycles, lock from edge 10 -> RUN from edge 21
    do_reset(3);
    chk("rst_pll_rst", int'(bus.pll_rst), 1);
    chk("rst_ready", int'(bus.ready), 0);
    for (int e = 0; e <= 22; e++) begin
      if (e == 10) bus.pll_locked = 1'b1;
      cyc(1);
      if (e == 2)  chk("t1_pll_rst_e3", int'(bus.pll_rst), 1);
      if (e == 3)  chk("t1_pll_rst_e4", int'(bus.pll_rst), 0);
      if (e == 19) chk("t1_ready_e20", int'(bus.ready), 0);
      if (e == 20) begin
        chk("t1_ready_e21", int'(bus.ready), 1);
        chk("t1_sys_rst_e21", int'(bus.sys_rst), 0);
        chk("t1_retry_e21", int'(bus.retry_count), 0);
      end
    end

    // 2: no lock -> three attempts then FAULT
    bus.pll_locked = 1'b0;
    do_reset(2);
    for (int e = 0; e <= 75; e++) begin
      cyc(1);
      if (e == 23) chk("t2_retry_1", int'(bus.retry_count), 1);
      if (e == 24) chk("t2_pulse2_on", int'(bus.pll_rst), 1);
      if (e == 27) chk("t2_pulse2_off", int'(bus.pll_rst), 0);
      if (e == 47) chk("t2_retry_2", int'(bus.retry_count), 2);
      if (e == 70) chk("t2_fault_early", int'(bus.fault), 0);
      if (e == 71) chk("t2_fault", int'(bus.fault), 1);
    end

    // 5: FAULT is sticky against lock; rst clears it
    bus.pll_locked = 1'b1;
    cyc(30);
    chk("t5_fault_sticky", int'(bus.fault), 1);
    chk("t5_ready_in_fault", int'(bus.ready), 0);
    rst = 1'b1;
    cyc(1);
    chk("t5_rst_fault", int'(bus.fault), 0);
    chk("t5_rst_pll_rst", int'(bus.pll_rst), 1);
    chk("t5_rst_retry", int'(bus.retry_count), 0);
    rst = 1'b0;

    // 3: one-cycle lock loss in RUN
    wait_ready(60);
    bus.pll_locked = 1'b0;
    cyc(1);
    bus.pll_locked = 1'b1;
    cyc(1);
    chk("t3_ready_still", int'(bus.ready), 1);
    cyc(1);
    chk("t3_ready_drop", int'(bus.ready), 0);
    chk("t3_sys_rst", int'(bus.sys_rst), 1);
    chk("t3_pll_rst", int'(bus.pll_rst), 1);
    chk("t3_loss", int'(bus.loss_count), 1);

    // 4: glitch during stability qualification, with one retry already consumed
    bus.pll_locked = 1'b0;
    do_reset(1);
    cyc(30);
    chk("t4_retry_pre", int'(bus.retry_count), 1);
    bus.pll_locked = 1'b1;
    wait_qual(4, 40);
    bus.pll_locked = 1'b0;
    cyc(1);
    bus.pll_locked = 1'b1;
    cyc(9);
    chk("t4_no_ready", int'(bus.ready), 0);
    chk("t4_retry_kept", int'(bus.retry_count), 1);
    wait_ready(20);
    chk("t4_retry_cleared", int'(bus.retry_count), 0);

    // 6: loss counter saturation
    for (int i = 0; i < 260; i++) begin
      wait_ready(40);
      bus.pll_locked = 1'b0;
      cyc(1);
      bus.pll_locked = 1'b1;
      cyc(2);
    end
    chk("t6_loss_sat", int'(bus.loss_count), 255);

    // Randomized lock traffic with occasional resets and long outages
    for (int i = 0; i < 250; i++) begin
      int v;
      v = int'($urandom_range(0, 99));
      if (v < 3) begin
        do_reset(int'($urandom_range(1, 3)));
      end else if (v < 8) begin
        bus.pll_locked = 1'b0;
        cyc(80);
      end else begin
        bus.pll_locked = ($urandom_range(0, 3) != 0);
        cyc(int'($urandom_range(1, 25)));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
